// File: rtl/meas_scheduler.sv
// rtl/meas_scheduler.sv - measurement round sequencer: clear, gate, settle, report, hold-off (optional SETTLE timeout: MEAS_SCHED_TIMEOUT_EN)
module meas_scheduler #(
    parameter int GATE_CYCLES    = 1_000_000,
    parameter int HOLDOFF_CYCLES = 10_000,
    parameter int TIMEOUT_CYCLES = 65_535,
    parameter int CNT_W          = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        single_shot,
    input  logic [1:0]  mode,
    output logic        meas_clear,
    output logic        gate,
    input  logic        meas_done,
    output logic        report_start,
    output logic [1:0]  report_mode,
    input  logic        report_busy,
    output logic        running,
    output logic [15:0] round_cnt,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_GATE   = 3'd2,
        S_SETTLE = 3'd3,
        S_REQ    = 3'd4,
        S_WAIT   = 3'd5,
        S_HOLD   = 3'd6
    } state_t;

    // Counters run down to zero, so each phase loads its length minus one.
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    // Reject illegal configurations at elaboration.
    if (GATE_CYCLES < 1 || HOLDOFF_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("meas_scheduler: GATE_CYCLES and TIMEOUT_CYCLES must be >= 1, HOLDOFF_CYCLES >= 0");
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             armed, armed_nxt;       // REQ may drive report_start (reporter seen idle)
    logic             one_shot, one_shot_nxt; // round was started by single_shot alone
    logic [1:0]       mode_q, mode_nxt;
    logic [15:0]      round_q, round_nxt;
    logic             round_over;             // report finished or settle timed out
    logic             hold_done;              // hold-off finished, pick next round or idle

`ifdef MEAS_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    logic tmo_q, tmo_nxt;
`endif

    assign running     = (state != S_IDLE);
    assign report_mode = mode_q;
    assign round_cnt   = round_q;

    // Next-state, counter and output decode for the round sequence.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        armed_nxt    = armed;
        one_shot_nxt = one_shot;
        mode_nxt     = mode_q;
        round_nxt    = round_q;
        round_over   = 1'b0;
        hold_done    = 1'b0;
        meas_clear   = 1'b0;
        gate         = 1'b0;
        report_start = 1'b0;
`ifdef MEAS_SCHED_TIMEOUT_EN
        tmo_nxt      = tmo_q;
`endif
        case (state)
            S_IDLE: begin
                if (enable || single_shot) begin
                    state_nxt    = S_CLEAR;
                    mode_nxt     = mode;
                    one_shot_nxt = !enable;
                end
            end
            S_CLEAR: begin
                meas_clear = 1'b1;
                cnt_nxt    = GATE_LOAD;
                state_nxt  = S_GATE;
            end
            S_GATE: begin
                gate = 1'b1;
                if (cnt == '0) begin
                    state_nxt = S_SETTLE;
`ifdef MEAS_SCHED_TIMEOUT_EN
                    cnt_nxt   = TMO_LOAD;
`endif
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_SETTLE: begin
                if (meas_done) begin
                    state_nxt = S_REQ;
                    // A reporter still busy from elsewhere must go idle before we ask.
                    armed_nxt = !report_busy;
                end
`ifdef MEAS_SCHED_TIMEOUT_EN
                else if (cnt == '0) begin
                    tmo_nxt    = 1'b1;
                    round_over = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
`endif
            end
            S_REQ: begin
                report_start = armed;
                if (armed) begin
                    if (report_busy) begin
                        state_nxt = S_WAIT;
                        armed_nxt = 1'b0;
                    end
                end else if (!report_busy) begin
                    armed_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                if (!report_busy) begin
                    round_nxt  = round_q + 16'd1;
                    round_over = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    hold_done = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (round_over) begin
            if (HOLDOFF_CYCLES > 0) begin
                state_nxt = S_HOLD;
                cnt_nxt   = HOLD_LOAD;
            end else begin
                hold_done = 1'b1;
            end
        end

        // Back-to-back rounds re-latch the requested mode; otherwise rest in IDLE.
        if (hold_done) begin
            if (enable && !one_shot) begin
                state_nxt = S_CLEAR;
                mode_nxt  = mode;
            end else begin
                state_nxt = S_IDLE;
            end
        end
    end

    // State, counter and latched round context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            armed    <= 1'b0;
            one_shot <= 1'b0;
            mode_q   <= 2'b00;
            round_q  <= 16'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            armed    <= armed_nxt;
            one_shot <= one_shot_nxt;
            mode_q   <= mode_nxt;
            round_q  <= round_nxt;
        end
    end

`ifdef MEAS_SCHED_TIMEOUT_EN
    // Sticky settle-timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_nxt;
        end
    end

    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_meas_scheduler.sv
// tb/tb_meas_scheduler.sv - self-checking bench for meas_scheduler
module tb_meas_scheduler;

    localparam int G = 8;
    localparam int H = 4;
    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        single_shot = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        meas_done = 1'b0;
    logic        report_busy = 1'b0;
    logic        meas_clear;
    logic        gate;
    logic        report_start;
    logic [1:0]  report_mode;
    logic        running;
    logic [15:0] round_cnt;
    logic        timeout_err;

    meas_scheduler #(
        .GATE_CYCLES    (G),
        .HOLDOFF_CYCLES (H),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .single_shot  (single_shot),
        .mode         (mode),
        .meas_clear   (meas_clear),
        .gate         (gate),
        .meas_done    (meas_done),
        .report_start (report_start),
        .report_mode  (report_mode),
        .report_busy  (report_busy),
        .running      (running),
        .round_cnt    (round_cnt),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // One round: d = settle cycles until meas_done, p = cycles reporter is already busy at
    // REQ entry, b = report_start cycles before busy, l = busy cycles; expected round length
    // and first report_start offset (relative to the meas_clear cycle).
    typedef struct {
        int         d;
        int         p;
        int         b;
        int         l;
        logic [1:0] mode;
        int         exp_len;
        int         exp_start;
    } vec_t;

    vec_t        tbl[5];
    vec_t        plan[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [1:0]  exp_mode = 2'b00;
    logic [15:0] exp_cnt = 16'd0;
    logic        exp_tmo = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] dut_outs();
        return {meas_clear, gate, report_start, running, report_mode, round_cnt, timeout_err};
    endfunction

    function automatic logic [22:0] exp_idle();
        return {4'b0000, exp_mode, exp_cnt, exp_tmo};
    endfunction

    // Timeline of one round: clear at 0, gate 1..G, settle d cycles, p blocked REQ cycles,
    // b start cycles, l wait cycles, then H hold cycles; round counted on first hold cycle.
    function automatic logic [22:0] exp_round(input vec_t v, input int off);
        int          s;
        logic [15:0] c;
        s = v.d + v.p;
        c = exp_cnt + ((off >= G + 1 + s + v.b + v.l) ? 16'd1 : 16'd0);
        return {off == 0, (off >= 1) && (off <= G), (off >= G + 1 + s) && (off <= G + s + v.b),
                1'b1, v.mode, c, exp_tmo};
    endfunction

    task automatic run_plan(input bit single, input bit noisy, input int abort_at);
        int n;
        n = plan.size();
        @(negedge clk);
        check("idle before start", dut_outs(), exp_idle());
        mode = plan[0].mode;
        if (single) single_shot = 1'b1;
        else enable = 1'b1;
        for (int k = 0; k < n; k++) begin
            vec_t v;
            int   s;
            int   len;
            int   first_start;
            int   bursts;
            int   run_cycles;
            logic prev_start;
            v = plan[k];
            s = v.d + v.p;
            len = G + 1 + s + v.b + v.l + H;
            first_start = -1;
            bursts = 0;
            run_cycles = 0;
            prev_start = 1'b0;
            for (int off = 0; off < len; off++) begin
                @(negedge clk);
                check($sformatf("round %0d cycle %0d outputs", k, off), dut_outs(), exp_round(v, off));
                if (report_start && first_start < 0) first_start = off;
                if (report_start && !prev_start) bursts++;
                if (running) run_cycles++;
                prev_start = report_start;
                if (k == 0 && off == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check("outputs during mid-round reset", dut_outs(), 32'd0);
                    enable = 1'b0;
                    single_shot = 1'b0;
                    meas_done = 1'b0;
                    report_busy = 1'b0;
                    return;
                end
                meas_done = (off <= G) ? 1'($urandom_range(0, 1)) : (off >= G + v.d);
                report_busy = ((off >= G + v.d) && (off < G + s)) ||
                              ((off >= G + s + v.b) && (off < G + s + v.b + v.l));
                mode = (off == len - 1 && k + 1 < n) ? plan[k + 1].mode : 2'($urandom);
                single_shot = noisy ? ($urandom_range(0, 3) == 0) : 1'b0;
                if (off == len - 1) enable = !single && (k + 1 < n);
                else if (noisy) enable = 1'($urandom_range(0, 1));
                else enable = !single && (k + 1 < n || off < 4);
            end
            check($sformatf("round %0d first report_start offset", k), first_start, v.exp_start);
            check($sformatf("round %0d report_start bursts", k), bursts, 1);
            check($sformatf("round %0d running cycles", k), run_cycles, v.exp_len);
            exp_cnt = exp_cnt + 16'd1;
            exp_mode = v.mode;
        end
        enable = 1'b0;
        single_shot = 1'b0;
        meas_done = 1'b0;
        report_busy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle after rounds", dut_outs(), exp_idle());
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.d = $urandom_range(1, 6);
        v.p = $urandom_range(0, 3);
        v.b = $urandom_range(1, 4);
        v.l = $urandom_range(1, 8);
        v.mode = 2'($urandom);
        v.exp_len = G + 1 + v.d + v.p + v.b + v.l + H;
        v.exp_start = G + 1 + v.d + v.p;
        return v;
    endfunction

    initial begin
        tbl[0] = '{3, 0, 1, 10, 2'b11, 27, 12};
        tbl[1] = '{1, 0, 2,  3, 2'b10, 19, 10};
        tbl[2] = '{4, 0, 1,  1, 2'b01, 19, 13};
        tbl[3] = '{2, 3, 2,  4, 2'b00, 24, 14};
        tbl[4] = '{5, 1, 3,  2, 2'b11, 24, 15};

        repeat (3) @(negedge clk);
        check("reset state", dut_outs(), 32'd0);
        rst_n = 1'b1;

        // single_shot round
        plan.delete();
        plan.push_back(tbl[0]);
        run_plan(1'b1, 1'b0, -1);

        // continuous rounds, enable dropped in gate of round 4, pre-busy and mode=0 rounds
        plan.delete();
        for (int i = 1; i < 5; i++) plan.push_back(tbl[i]);
        run_plan(1'b0, 1'b0, -1);

        // randomized continuous batch with noise on enable/single_shot/mode/meas_done
        plan.delete();
        for (int i = 0; i < 8; i++) plan.push_back(rand_vec());
        run_plan(1'b0, 1'b1, -1);

        // randomized single-shot rounds
        for (int r = 0; r < 3; r++) begin
            plan.delete();
            plan.push_back(rand_vec());
            run_plan(1'b1, 1'b1, -1);
        end

`ifdef MEAS_SCHED_TIMEOUT_EN
        // meas_done never arrives: T settle cycles, then hold with timeout_err, no report
        @(negedge clk);
        single_shot = 1'b1;
        mode = 2'b10;
        for (int off = 0; off < G + 1 + T + H; off++) begin
            @(negedge clk);
            single_shot = 1'b0;
            check($sformatf("timeout cycle %0d outputs", off), dut_outs(),
                  {off == 0, (off >= 1) && (off <= G), 1'b0, 1'b1, 2'b10, exp_cnt, off >= G + 1 + T});
            mode = 2'($urandom);
        end
        exp_tmo = 1'b1;
        exp_mode = 2'b10;
        @(negedge clk);
        check("idle after timeout", dut_outs(), exp_idle());
`endif

        // reset asserted during WAIT (cycles 13..18 of this round)
        plan.delete();
        plan.push_back('{2, 0, 2, 6, 2'b01, 23, 11});
        run_plan(1'b1, 1'b0, 15);
        exp_cnt = 16'd0;
        exp_mode = 2'b00;
        exp_tmo = 1'b0;
        @(negedge clk);
        check("held in reset", dut_outs(), 32'd0);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle after reset release", dut_outs(), exp_idle());
        end

        // normal operation after reset
        plan.delete();
        plan.push_back(tbl[1]);
        run_plan(1'b1, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
